// File: rtl/zap_mult_acc_if.sv
// Handshake and operand/result bundle for zap_mult_acc.
interface zap_mult_acc_if #(
  parameter int WIDTH = 32
);
  logic             i_clear;
  logic             i_start;
  logic             i_long;
  logic             i_signed;
  logic             i_acc;
  logic [WIDTH-1:0] i_rm;
  logic [WIDTH-1:0] i_rs;
  logic [WIDTH-1:0] i_rn;
  logic [WIDTH-1:0] i_rh;
  logic [WIDTH-1:0] o_rd_lo;
  logic [WIDTH-1:0] o_rd_hi;
  logic             o_busy;
  logic             o_done;
  logic             o_z;
  logic             o_n;

  modport master (
    output i_clear, i_start, i_long, i_signed, i_acc, i_rm, i_rs, i_rn, i_rh,
    input  o_rd_lo, o_rd_hi, o_busy, o_done, o_z, o_n
  );

  modport slave (
    input  i_clear, i_start, i_long, i_signed, i_acc, i_rm, i_rs, i_rn, i_rh,
    output o_rd_lo, o_rd_hi, o_busy, o_done, o_z, o_n
  );
endinterface

// File: rtl/zap_mult_acc.sv
// Multi-cycle multiply-accumulate using one (WIDTH/2)x(WIDTH/2) multiplier.
// Define ZAP_MULT_EARLY_TERM_EN to skip the high*high pass for short operations.
module zap_mult_acc #(
  parameter int WIDTH = 32
) (
  input  logic          i_clk,
  input  logic          i_reset,
  zap_mult_acc_if.slave bus
);
  localparam int H  = WIDTH / 2;
  localparam int W2 = 2 * WIDTH;

  typedef enum logic [2:0] {IDLE, P0, P1, P2, P3, ACC} state_t;

  state_t           state_q, state_d;
  logic             start_fire;

  logic [WIDTH-1:0] rm_q, rs_q, acc_lo_q, acc_hi_q;
  logic             neg_q, long_q;
  logic [W2-1:0]    prod_q;
  logic [WIDTH-1:0] rd_lo_q, rd_hi_q;
  logic             done_q, z_q, n_q;

  logic             rm_neg, rs_neg;
  logic [WIDTH-1:0] rm_mag, rs_mag;
  logic [H-1:0]     pp_a, pp_b;
  logic [WIDTH-1:0] pp;
  logic [W2-1:0]    pp_ext, prod_fin, sum, result;

  assign start_fire = (state_q == IDLE) && bus.i_start && !bus.i_clear;

  // NOTE: the reset branch sits inside the clocked block, so reset is sampled on the edge like any other input.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // NOTE: default assigned first so every path drives state_d and no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (bus.i_start) state_d = P0;
        P0:      state_d = P1;
        P1:      state_d = P2;
`ifdef ZAP_MULT_EARLY_TERM_EN
        P2:      state_d = long_q ? P3 : ACC;
`else
        P2:      state_d = P3;
`endif
        P3:      state_d = ACC;
        ACC:     state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Signed handling only applies in long mode; short results come from raw operands.
  assign rm_neg = bus.i_long && bus.i_signed && bus.i_rm[WIDTH-1];
  assign rs_neg = bus.i_long && bus.i_signed && bus.i_rs[WIDTH-1];
  assign rm_mag = rm_neg ? -bus.i_rm : bus.i_rm;
  assign rs_mag = rs_neg ? -bus.i_rs : bus.i_rs;

  always_comb begin
    pp_a   = '0;
    pp_b   = '0;
    pp_ext = '0;
    case (state_q)
      P0: begin pp_a = rm_q[H-1:0];     pp_b = rs_q[H-1:0];     end
      P1: begin pp_a = rm_q[H-1:0];     pp_b = rs_q[WIDTH-1:H]; end
      P2: begin pp_a = rm_q[WIDTH-1:H]; pp_b = rs_q[H-1:0];     end
      P3: begin pp_a = rm_q[WIDTH-1:H]; pp_b = rs_q[WIDTH-1:H]; end
      default: ;
    endcase
    pp = WIDTH'(pp_a) * WIDTH'(pp_b);
    case (state_q)
      P0:      pp_ext = W2'(pp);
      P1, P2:  pp_ext = W2'(pp) << H;
      P3:      pp_ext = W2'(pp) << WIDTH;
      default: pp_ext = '0;
    endcase
  end

  always_comb begin
    prod_fin = neg_q ? -prod_q : prod_q;
    sum      = {acc_hi_q, acc_lo_q} + prod_fin;
    result   = long_q ? sum : {{WIDTH{1'b0}}, sum[WIDTH-1:0]};
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rm_q     <= '0;
      rs_q     <= '0;
      acc_lo_q <= '0;
      acc_hi_q <= '0;
      neg_q    <= 1'b0;
      long_q   <= 1'b0;
      prod_q   <= '0;
      rd_lo_q  <= '0;
      rd_hi_q  <= '0;
      done_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_fire) begin
        rm_q     <= rm_mag;
        rs_q     <= rs_mag;
        neg_q    <= rm_neg ^ rs_neg;
        long_q   <= bus.i_long;
        acc_lo_q <= bus.i_acc ? bus.i_rn : '0;
        acc_hi_q <= (bus.i_acc && bus.i_long) ? bus.i_rh : '0;
        prod_q   <= '0;
      end else if (!bus.i_clear && state_q inside {P0, P1, P2, P3}) begin
        prod_q <= prod_q + pp_ext;
      end
      if (!bus.i_clear && state_q == ACC) begin
        rd_lo_q <= result[WIDTH-1:0];
        rd_hi_q <= result[W2-1:WIDTH];
        z_q     <= (result == '0);
        n_q     <= long_q ? result[W2-1] : result[WIDTH-1];
        done_q  <= 1'b1;
      end
    end
  end

  assign bus.o_rd_lo = rd_lo_q;
  assign bus.o_rd_hi = rd_hi_q;
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_done  = done_q;
  assign bus.o_z     = z_q;
  assign bus.o_n     = n_q;
endmodule

// File: tb/tb_zap_mult_acc.sv
// Directed bench for zap_mult_acc at WIDTH=32; honours ZAP_MULT_EARLY_TERM_EN for short latency.
module tb_zap_mult_acc;
  localparam int WIDTH = 32;
`ifdef ZAP_MULT_EARLY_TERM_EN
  localparam int SHORT_LAT = 5;
`else
  localparam int SHORT_LAT = 6;
`endif
  localparam int LONG_LAT = 6;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   lat;
  int   dn;

  always #5 clk = ~clk;

  zap_mult_acc_if #(.WIDTH(WIDTH)) bus ();

  zap_mult_acc #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus.slave)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic lng, input logic sgn, input logic acc,
                       input logic [31:0] rm, input logic [31:0] rs,
                       input logic [31:0] rn, input logic [31:0] rh);
    bus.i_long   = lng;
    bus.i_signed = sgn;
    bus.i_acc    = acc;
    bus.i_rm     = rm;
    bus.i_rs     = rs;
    bus.i_rn     = rn;
    bus.i_rh     = rh;
    bus.i_start  = 1'b1;
  endtask

  // Counts negedges after the start-sample edge until o_done; -1 if it never comes.
  task automatic wait_done(output int l);
    logic got;
    got = 1'b0;
    l   = 0;
    while (!got && l < 20) begin
      @(negedge clk);
      bus.i_start = 1'b0;
      l++;
      got = bus.o_done;
    end
    if (!got) l = -1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.i_clear  = 1'b0;
    bus.i_start  = 1'b0;
    bus.i_long   = 1'b0;
    bus.i_signed = 1'b0;
    bus.i_acc    = 1'b0;
    bus.i_rm     = '0;
    bus.i_rs     = '0;
    bus.i_rn     = '0;
    bus.i_rh     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.o_busy), 64'd0);
    check("rst_done", 64'(bus.o_done), 64'd0);
    check("rst_res",  {bus.o_rd_hi, bus.o_rd_lo}, 64'd0);
    check("rst_zn",   64'({bus.o_z, bus.o_n}), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Short MAC
    issue(1'b0, 1'b0, 1'b1, 32'h0001_0003, 32'h0002_0005, 32'd7, 32'h0);
    @(negedge clk);
    bus.i_start = 1'b0;
    check("mac_busy", 64'(bus.o_busy), 64'd1);
    wait_done(lat);
    lat++;
    check("mac_lat", 64'(lat), 64'(SHORT_LAT));
    check("mac_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'h0000_0000_000B_0016);
    check("mac_zn",  64'({bus.o_z, bus.o_n}), 64'd0);
    @(negedge clk);
    check("mac_pulse", 64'(bus.o_done), 64'd0);
    check("mac_hold",  64'(bus.o_rd_lo), 64'h000B_0016);

    // Signed long: -1 * 2
    issue(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h1111, 32'h2222);
    wait_done(lat);
    check("sl_lat", 64'(lat), 64'(LONG_LAT));
    check("sl_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_FFFF_FFFE);
    check("sl_zn",  64'({bus.o_z, bus.o_n}), 64'b01);

    // i_signed ignored in short mode
    issue(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 32'h0, 32'h55);
    wait_done(lat);
    check("ss_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'h0000_0000_FFFF_FFFE);
    check("ss_n",   64'(bus.o_n), 64'd1);

    // Unsigned long wrap
    issue(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
    wait_done(lat);
    check("uw_lat", 64'(lat), 64'(LONG_LAT));
    check("uw_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_0000_0000);

    // Signed long, most-negative operand, with accumulate
    issue(1'b1, 1'b1, 1'b1, 32'h8000_0000, 32'd3, 32'h8000_0000, 32'h0);
    wait_done(lat);
    check("smin_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_0000_0000);
    check("smin_zn",  64'({bus.o_z, bus.o_n}), 64'b01);

    // Abort in P2
    issue(1'b1, 1'b0, 1'b0, 32'd5, 32'd7, 32'h0, 32'h0);
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_clear = 1'b0;
    check("ab_busy", 64'(bus.o_busy), 64'd0);
    dn = 0;
    repeat (8) begin
      dn += int'(bus.o_done);
      @(negedge clk);
    end
    check("ab_nodone", 64'(dn), 64'd0);
    check("ab_hold",   {bus.o_rd_hi, bus.o_rd_lo}, 64'hFFFF_FFFF_0000_0000);
    check("ab_nhold",  64'(bus.o_n), 64'd1);

    // Start together with clear in IDLE
    issue(1'b0, 1'b0, 1'b0, 32'd3, 32'd3, 32'h0, 32'h0);
    bus.i_clear = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_clear = 1'b0;
    check("sc_busy", 64'(bus.o_busy), 64'd0);
    dn = 0;
    repeat (8) begin
      dn += int'(bus.o_done);
      @(negedge clk);
    end
    check("sc_nodone", 64'(dn), 64'd0);

    // Zero result with accumulator disabled
    issue(1'b0, 1'b0, 1'b0, 32'h0, 32'h1234, 32'd5, 32'h0);
    wait_done(lat);
    check("zero_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'd0);
    check("zero_zn",  64'({bus.o_z, bus.o_n}), 64'b10);

    // Back-to-back: new start in the o_done cycle
    issue(1'b0, 1'b0, 1'b1, 32'd3, 32'd4, 32'd1, 32'h0);
    wait_done(lat);
    check("bb_a_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'd13);
    issue(1'b1, 1'b0, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0);
    wait_done(lat);
    check("bb_b_lat", 64'(lat), 64'(LONG_LAT));
    check("bb_b_res", {bus.o_rd_hi, bus.o_rd_lo}, 64'h0000_0001_0000_0000);

    // Reset during P1
    issue(1'b1, 1'b0, 1'b0, 32'd7, 32'd9, 32'h0, 32'h0);
    @(negedge clk);
    bus.i_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mr_res",  {bus.o_rd_hi, bus.o_rd_lo}, 64'd0);
    check("mr_busy", 64'(bus.o_busy), 64'd0);
    dn = 0;
    repeat (8) begin
      dn += int'(bus.o_done);
      @(negedge clk);
    end
    check("mr_nodone", 64'(dn), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/zap_mult_acc.md
ZAP_MULT_ACC -- requirements
Module: zap_mult_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; even, >=8.
REQ-002 SHALL have i_clk  input  1  clock; all state changes on rising edge.
REQ-003 SHALL have i_reset  input  1  reset, synchronous, active-high.
REQ-004 SHALL have i_clear  input  1  synchronous abort of any operation in flight.
REQ-005 SHALL have i_start  input  1  begin operation; operands sampled on the same edge.
REQ-006 SHALL have i_long  input  1  1 = 2*WIDTH-bit product, 0 = WIDTH-bit product.
REQ-007 SHALL have i_signed  input  1  1 = two's-complement operands; long mode only.
REQ-008 SHALL have i_acc  input  1  1 = add accumulator, 0 = accumulator treated as zero.
REQ-009 SHALL have i_rm, i_rs  input  WIDTH  multiplicand, multiplier.
REQ-010 SHALL have i_rn  input  WIDTH  accumulator low word.
REQ-011 SHALL have i_rh  input  WIDTH  accumulator high word; long mode only.
REQ-012 SHALL have o_rd_lo, o_rd_hi  output  WIDTH  result low/high word, registered.
REQ-013 SHALL have o_busy  output  1  high in every non-IDLE state.
REQ-014 SHALL have o_done  output  1  one-cycle pulse; results valid this cycle.
REQ-015 SHALL have o_z, o_n  output  1  zero/negative flags of result, registered with it.

Function
REQ-016 SHALL use states IDLE, P0, P1, P2, P3, ACC; one state per cycle, one HxH unsigned partial product per state, H = WIDTH/2.
REQ-017 SHALL in IDLE with i_start=1, i_clear=0 register operands and mode bits and go to P0; other inputs ignored thereafter.
REQ-018 SHALL compute P0 = lo(rm)*lo(rs), P1 = lo*hi, P2 = hi*lo, P3 = hi*hi on magnitudes, then P3 -> ACC -> IDLE.
REQ-019 SHALL in signed long mode take magnitudes of rm, rs and negate the 2*WIDTH product when operand signs differ.
REQ-020 SHALL in ACC form long: {rh,rn}+product mod 2^(2*WIDTH); short: rn+product mod 2^WIDTH, o_rd_hi = 0.
REQ-021 SHALL register results and flags and pulse o_done on the ACC->IDLE edge; o_done is high in the first IDLE cycle.
REQ-022 SHALL set o_z when all result bits (2*WIDTH long, WIDTH short) are zero; o_n = MSB of that result.
REQ-023 SHALL hold o_rd_lo, o_rd_hi, o_z, o_n until the next completion.
REQ-024 SHALL ignore i_start while o_busy=1.
REQ-025 SHALL on i_clear in any state go to IDLE next edge, no o_done, results unchanged; i_clear wins over simultaneous i_start.
REQ-026 SHALL accept i_start in the cycle o_done is high (back-to-back), giving a new o_done 6 cycles later.
REQ-027 SHALL ignore i_signed in short mode (low WIDTH bits identical).

Reset
REQ-028 SHALL on i_reset go to IDLE, clear all outputs and internal registers to 0; i_reset overrides i_clear and i_start, including mid-operation.

Configuration
REQ-029 SHALL with macro ZAP_MULT_EARLY_TERM_EN defined skip P3 for short operations (P2 -> ACC), o_done 5 cycles after start.
REQ-030 SHALL without ZAP_MULT_EARLY_TERM_EN visit all states for every operation, o_done 6 cycles after the start-sample edge.
REQ-031 SHALL give identical results, flags and long-mode latency in both builds.

Verification (WIDTH=32)
REQ-032 SHALL cover short MAC: rm=0x0001_0003, rs=0x0002_0005, rn=7, i_acc=1 -> o_rd_lo=0x000B_0016, o_rd_hi=0, o_done 6 cycles after start (5 with macro).
REQ-033 SHALL cover signed long: rm=0xFFFF_FFFF, rs=2, i_signed=1, i_acc=0 -> {hi,lo}=0xFFFF_FFFF_FFFF_FFFE, o_n=1, o_z=0.
REQ-034 SHALL cover unsigned long wrap: rm=rs=0xFFFF_FFFF, i_acc=1, rh=0, rn=0xFFFF_FFFF -> {hi,lo}=0xFFFF_FFFF_0000_0000.
REQ-035 SHALL cover zero result: rm=0, rs=0x1234, i_acc=0 -> o_rd_lo=0, o_z=1.
REQ-036 SHALL cover abort: i_clear in P2 -> IDLE next cycle, no o_done, prior results held; i_start with i_clear in IDLE -> no operation.
REQ-037 SHALL cover back-to-back start on o_done cycle and i_reset in P1 -> outputs 0, IDLE, no o_done.
